tff_div_arbiter: RTL and testbench

Controller that shares one STAGES-deep toggle-flip-flop divider chain between two requesters. Each requester asks for a burst of N rising edges on a selected chain tap. The block arbitrates round-robin, clears and enables the chain, counts tap rising edges, and pulses a per-requester done. It sits beside the T-FF divider primitives as their sequencer, so a single chain serves multiple timing consumers.

---
 rtl/tff_div_arbiter.sv | 97 +++++++++
 tb/tb_tff_div_arbiter.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/tff_div_arbiter.sv
// Round-robin sequencer that lends one T-FF divider chain to two requesters,
// counting rising edges on a chosen tap and pulsing done when a burst completes.
module tff_div_arbiter #(
  parameter int STAGES = 4,
  parameter int CNT_W  = 8,
  parameter int TAP_W  = $clog2(STAGES)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic [CNT_W-1:0]  cnt0,
  input  logic [CNT_W-1:0]  cnt1,
  input  logic [TAP_W-1:0]  tap0,
  input  logic [TAP_W-1:0]  tap1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              done0,
  output logic              done1,
  output logic              busy,
  output logic [STAGES-1:0] chain_q,
  output logic              tout
);

  localparam int IDX_W = (STAGES > 1) ? $clog2(STAGES) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  state_t             state;
  state_t             state_nxt;
  logic               last;
  logic               winner;
  logic [CNT_W-1:0]   remaining;
  logic [IDX_W-1:0]   tap_l;
  logic [CNT_W-1:0]   sel_cnt;
  logic [TAP_W-1:0]   sel_tap;
  logic [IDX_W-1:0]   sel_tap_c;
  logic [STAGES-1:0]  low_mask;
  logic               rise;
  logic               any_req;

  // In LOAD `last` already names the winner, so it selects that requester's inputs.
  assign any_req   = req0 | req1;
  assign winner    = (req0 && req1) ? ~last : req1;
  assign sel_cnt   = last ? cnt1 : cnt0;
  assign sel_tap   = last ? tap1 : tap0;
  assign sel_tap_c = ({{(32-TAP_W){1'b0}}, sel_tap} >= 32'(STAGES))
                     ? IDX_W'(STAGES - 1) : IDX_W'(sel_tap);

  assign low_mask = (STAGES'(1) << tap_l) - STAGES'(1);
  assign rise     = (state == RUN) && ((chain_q & low_mask) == low_mask) && !chain_q[tap_l];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (any_req) state_nxt = LOAD;
      LOAD: state_nxt = (sel_cnt != CNT_W'(0)) ? RUN : DONE;
      RUN:  if (rise && remaining == CNT_W'(1)) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The chain behaves as a binary up-counter while enabled; it and tap_l hold after DONE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      chain_q   <= '0;
      remaining <= '0;
      tap_l     <= '0;
      last      <= 1'b1;
    end else begin
      if (state == IDLE && any_req) last <= winner;
      if (state == LOAD) begin
        chain_q   <= '0;
        remaining <= sel_cnt;
        tap_l     <= sel_tap_c;
      end
      if (state == RUN) begin
        chain_q <= chain_q + STAGES'(1);
        if (rise) remaining <= remaining - CNT_W'(1);
      end
    end
  end

  assign busy  = (state != IDLE);
  assign gnt0  = busy && !last;
  assign gnt1  = busy && last;
  assign done0 = (state == DONE) && !last;
  assign done1 = (state == DONE) && last;
  assign tout  = chain_q[tap_l];

endmodule

// File: tb/tb_tff_div_arbiter.sv
// Scoreboard bench for tff_div_arbiter: a driver pushes the expected outcome of each
// burst, and an independent monitor checks it whenever a done pulse appears.
module tb_tff_div_arbiter;

  localparam int STAGES = 4;
  localparam int CNT_W  = 8;
  localparam int TAP_W  = 3;
  localparam int LIMIT  = 1000;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              req0 = 1'b0, req1 = 1'b0;
  logic [CNT_W-1:0]  cnt0 = '0, cnt1 = '0;
  logic [TAP_W-1:0]  tap0 = '0, tap1 = '0;
  logic              gnt0, gnt1, done0, done1, busy, tout;
  logic [STAGES-1:0] chain_q;

  typedef struct {
    int who;
    int run;
    int fin;
    int tout;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   model_last = 1;

  tff_div_arbiter #(.STAGES(STAGES), .CNT_W(CNT_W), .TAP_W(TAP_W)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1),
    .cnt0(cnt0), .cnt1(cnt1),
    .tap0(tap0), .tap1(tap1),
    .gnt0(gnt0), .gnt1(gnt1),
    .done0(done0), .done1(done1),
    .busy(busy), .chain_q(chain_q), .tout(tout)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // A burst of n tap-k edges needs (2n-1)*2^k enabled cycles; the chain wraps mod 2^STAGES.
  function automatic exp_t modelBurst(input int who, input int n, input int tap);
    exp_t e;
    int   k;
    k      = (tap >= STAGES) ? STAGES - 1 : tap;
    e.who  = who;
    e.run  = (n == 0) ? 0 : (2 * n - 1) * (1 << k);
    e.fin  = e.run % (1 << STAGES);
    e.tout = (n == 0) ? 0 : 1;
    return e;
  endfunction

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_busy"}, busy, 0);
    checkOutput({tag, "_gnt0"}, gnt0, 0);
    checkOutput({tag, "_gnt1"}, gnt1, 0);
    checkOutput({tag, "_done0"}, done0, 0);
    checkOutput({tag, "_done1"}, done1, 0);
    checkOutput({tag, "_chain"}, chain_q, 0);
    checkOutput({tag, "_tout"}, tout, 0);
  endtask

  task automatic waitDone(input bit wait0, input bit wait1, input int delay1);
    bit pend0, pend1, raise1;
    int cyc;
    pend0  = wait0;
    pend1  = wait1;
    raise1 = wait1 && (delay1 > 0);
    cyc    = 1;
    while ((pend0 || pend1) && cyc < LIMIT) begin
      @(negedge clk);
      cyc++;
      if (done0) begin req0 = 1'b0; pend0 = 1'b0; end
      if (done1) begin req1 = 1'b0; pend1 = 1'b0; end
      if (raise1 && cyc == delay1) begin req1 = 1'b1; raise1 = 1'b0; end
    end
    if (pend0 || pend1) begin
      checkOutput("burst_timeout", cyc, -1);
      req0 = 1'b0;
      req1 = 1'b0;
    end
  endtask

  // delay1 > 0 raises req1 that many cycles into req0's burst (only used with use0).
  task automatic applyStimulus(input bit use0, input bit use1, input int c0, input int t0,
                               input int c1, input int t1, input int delay1);
    int first;
    int second;
    @(negedge clk);
    cnt0 = CNT_W'(c0);
    tap0 = TAP_W'(t0);
    cnt1 = CNT_W'(c1);
    tap1 = TAP_W'(t1);
    if (use0 && use1 && delay1 == 0) first = (model_last == 1) ? 0 : 1;
    else if (use0)                  first = 0;
    else                            first = 1;
    second = 1 - first;
    sb_q.push_back(first == 0 ? modelBurst(0, c0, t0) : modelBurst(1, c1, t1));
    model_last = first;
    if (use0 && use1) begin
      sb_q.push_back(second == 0 ? modelBurst(0, c0, t0) : modelBurst(1, c1, t1));
      model_last = second;
    end
    req0 = use0;
    req1 = use1 && (delay1 == 0);
    @(negedge clk);
    checkOutput("gnt_latency", (first == 0) ? gnt0 : gnt1, 1);
    waitDone(use0, use1, delay1);
  endtask

  // Monitor: pops one expectation per done pulse, independent of the driver.
  int busy_len  = 0;
  bit after_done = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      busy_len   = 0;
      after_done = 1'b0;
    end else begin
      if (after_done) begin
        checkOutput("idle_after_done", busy, 0);
        after_done = 1'b0;
      end
      busy_len = busy ? busy_len + 1 : 0;
      if (done0 || done1) begin
        checkOutput("done_onehot", done0 & done1, 0);
        checkOutput("sb_nonempty", sb_q.size() > 0, 1);
        if (sb_q.size() > 0) begin
          e = sb_q.pop_front();
          checkOutput("done_who", done1 ? 1 : 0, e.who);
          checkOutput("busy_cycles", busy_len, e.run + 2);
          checkOutput("final_chain", chain_q, e.fin);
          checkOutput("done_tout", tout, e.tout);
          checkOutput("done_gnt", (e.who == 0) ? gnt0 : gnt1, 1);
        end
        after_done = 1'b1;
      end
    end
  end

  initial begin
    #3;
    checkIdleOutputs("reset");
    @(negedge clk);
    rst = 1'b1;

    applyStimulus(1, 0, 3, 1, 0, 0, 0);
    applyStimulus(1, 1, 1, 0, 1, 0, 0);
    applyStimulus(1, 1, 1, 0, 1, 0, 0);
    applyStimulus(0, 1, 0, 0, 2, 3, 0);
    applyStimulus(0, 1, 0, 0, 2, 7, 0);
    applyStimulus(1, 0, 0, 2, 0, 0, 0);
    applyStimulus(1, 1, 3, 1, 2, 0, 4);

    // Abort a long burst mid-RUN; nothing from it may complete.
    @(negedge clk);
    cnt0 = CNT_W'(5);
    tap0 = TAP_W'(2);
    req0 = 1'b1;
    sb_q.push_back(modelBurst(0, 5, 2));
    repeat (10) @(negedge clk);
    #2 rst = 1'b0;
    #1 checkIdleOutputs("midrun_reset");
    sb_q.delete();
    model_last = 1;
    @(negedge clk);
    rst = 1'b1;
    sb_q.push_back(modelBurst(0, 5, 2));
    model_last = 0;
    @(negedge clk);
    checkOutput("regrant_after_reset", gnt0, 1);
    waitDone(1, 0, 0);

    for (int i = 0; i < 25; i++) begin
      int mode;
      mode = $urandom_range(0, 3);
      applyStimulus(mode != 1, mode != 0,
                    $urandom_range(0, 6), $urandom_range(0, 7),
                    $urandom_range(0, 6), $urandom_range(0, 7),
                    (mode == 3) ? $urandom_range(2, 6) : 0);
    end

    repeat (3) @(negedge clk);
    checkOutput("sb_drained", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    errors++;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
